// File: rtl/uart_msg_framer.sv
`default_nettype none
// ============================================================================
//  uart_msg_framer
//  Frames each buffered UART message as header, data words and XOR trailer.
//  Revision: 1.0
// ============================================================================
module uart_msg_framer #(
    parameter logic [3:0] CHAN_ID = 4'd0,
    parameter int         SETTLE  = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        GOT_FULL_MESSAGE,
    input  logic [7:0]  MSG_LEN,
    input  logic        PARITY_IN,
    input  logic [15:0] FIFO_Q,
    output logic        RD_REQ,
    output logic        MSG_START,
    output logic [15:0] TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic        TX_SOP,
    output logic        TX_EOP,
    output logic        BUSY
);

    localparam logic [4:0] C_SETTLE_LAST = (SETTLE > 1) ? 5'(SETTLE - 1) : 5'd0;
    localparam logic [4:0] C_DROP_LAST   = 5'd15;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_START  = 4'd1,
        S_LATCH  = 4'd2,
        S_SETTLE = 4'd3,
        S_HDR    = 4'd4,
        S_DATA   = 4'd5,
        S_TRL    = 4'd6,
        S_DROP   = 4'd7
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic              par_q, par_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [7:0]        words_req_q, words_req_d;
    logic [7:0]        words_sent_q, words_sent_d;
    logic [15:0]       csum_q, csum_d;
    logic [1:0][15:0]  skid_q, skid_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              inflight_q, inflight_d;

    logic [15:0]       w_header;
    logic [15:0]       w_head;
    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_occ;

    assign w_header = {CHAN_ID, 3'b000, par_q, len_q};
    assign w_head   = skid_q[rd_ptr_q];
    assign w_push   = inflight_q;
    assign BUSY     = (state_q != S_IDLE);

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        par_d        = par_q;
        cnt_d        = cnt_q;
        words_req_d  = words_req_q;
        words_sent_d = words_sent_q;
        csum_d       = csum_q;
        RD_REQ       = 1'b0;
        MSG_START    = 1'b0;
        TX_DATA      = 16'h0000;
        TX_VALID     = 1'b0;
        TX_SOP       = 1'b0;
        TX_EOP       = 1'b0;
        w_pop        = 1'b0;
        w_occ        = 3'd0;

        case (state_q)
            S_IDLE: begin
                if (GOT_FULL_MESSAGE) state_d = S_START;
            end
            S_START: begin
                MSG_START = 1'b1;
                state_d   = S_LATCH;
            end
            S_LATCH: begin
                len_d        = MSG_LEN;
                par_d        = PARITY_IN;
                cnt_d        = 5'd0;
                words_req_d  = 8'd0;
                words_sent_d = 8'd0;
                state_d      = (MSG_LEN == 8'd0) ? S_DROP : S_SETTLE;
            end
            S_SETTLE: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == C_SETTLE_LAST) state_d = S_HDR;
            end
            S_HDR: begin
                TX_VALID = 1'b1;
                TX_SOP   = 1'b1;
                TX_DATA  = w_header;
                csum_d   = w_header;
                if (TX_READY) state_d = S_DATA;
            end
            S_DATA: begin
                TX_VALID = (count_q != 2'd0);
                TX_DATA  = TX_VALID ? w_head : 16'h0000;
                w_pop    = TX_VALID & TX_READY;
                if (w_pop) begin
                    csum_d       = csum_q ^ w_head;
                    words_sent_d = words_sent_q + 8'd1;
                    if (words_sent_q + 8'd1 == len_q) state_d = S_TRL;
                end
                // The slot freed by this cycle's pop counts as available, so
                // reads keep pace with a one-word-per-cycle drain.
                w_occ = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
                if ((words_req_q < len_q) && (w_occ < 3'd2)) begin
                    RD_REQ      = 1'b1;
                    words_req_d = words_req_q + 8'd1;
                end
            end
            S_TRL: begin
                TX_VALID = 1'b1;
                TX_EOP   = 1'b1;
                TX_DATA  = csum_q;
                if (TX_READY) state_d = S_IDLE;
            end
            S_DROP: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == C_DROP_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        skid_d     = skid_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + {1'b0, w_push} - {1'b0, w_pop};
        inflight_d = RD_REQ;
        if (w_push) begin
            skid_d[wr_ptr_q] = FIFO_Q;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (w_pop) rd_ptr_d = ~rd_ptr_q;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            len_q        <= 8'd0;
            par_q        <= 1'b0;
            cnt_q        <= 5'd0;
            words_req_q  <= 8'd0;
            words_sent_q <= 8'd0;
            csum_q       <= 16'h0000;
            skid_q       <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            par_q        <= par_d;
            cnt_q        <= cnt_d;
            words_req_q  <= words_req_d;
            words_sent_q <= words_sent_d;
            csum_q       <= csum_d;
            skid_q       <= skid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_msg_framer.sv
`default_nettype none
// ============================================================================
//  tb_uart_msg_framer
//  Upstream FIFO/flag model, random stream stalls and a frame-level reference.
//  Revision: 1.0
// ============================================================================
module tb_uart_msg_framer;

    localparam logic [3:0] CHAN = 4'd5;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        GOT_FULL_MESSAGE = 1'b0;
    logic [7:0]  MSG_LEN = 8'd0;
    logic        PARITY_IN = 1'b0;
    logic [15:0] FIFO_Q = 16'h0000;
    logic        TX_READY = 1'b0;
    logic        RD_REQ, MSG_START, TX_VALID, TX_SOP, TX_EOP, BUSY;
    logic [15:0] TX_DATA;

    uart_msg_framer #(.CHAN_ID(CHAN), .SETTLE(3)) dut (
        .CLK(CLK), .RST(RST), .GOT_FULL_MESSAGE(GOT_FULL_MESSAGE),
        .MSG_LEN(MSG_LEN), .PARITY_IN(PARITY_IN), .FIFO_Q(FIFO_Q),
        .RD_REQ(RD_REQ), .MSG_START(MSG_START), .TX_DATA(TX_DATA),
        .TX_VALID(TX_VALID), .TX_READY(TX_READY), .TX_SOP(TX_SOP),
        .TX_EOP(TX_EOP), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       sop;
        logic       eop;
        logic [15:0] data;
        int         cyc;
    } beat_t;

    typedef struct {
        int          len;
        bit          par;
        logic [15:0] w [4];
        int          rmode;
        logic [15:0] exp_hdr;
        logic [15:0] exp_trl;
        int          exp_rd;
    } vec_t;

    int          n_vec = 0, n_err = 0;
    logic [15:0] fifo [$];
    logic [17:0] exp_q [$];
    beat_t       acc [$];
    int          ms_log [$];
    int          pend_len = 0;
    bit          pend_par = 0, clr_armed = 0;
    int          cyc = 0, rmode = 0;
    int          rd_total = 0, data_acc = 0, eop_count = 0;
    int          stall_err = 0, occ_err = 0, both_err = 0, valid_cycles = 0;
    int          last_idle_cyc = 0;
    bit          prev_stall = 0, s_rd = 0, s_ms = 0;
    logic [17:0] prev_out = '0;
    vec_t        tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: upstream reacts to the previous cycle's strobes, then the
    // downstream ready is chosen and all outputs are sampled mid-cycle.
    task automatic step();
        @(posedge CLK);
        #1;
        if (s_rd) begin
            if (fifo.size() > 0) FIFO_Q = fifo.pop_front();
            else FIFO_Q = 16'hDEAD;
            if (clr_armed) begin
                GOT_FULL_MESSAGE = 1'b0;
                clr_armed = 1'b0;
            end
        end
        if (s_ms) begin
            MSG_LEN   = 8'(pend_len);
            PARITY_IN = pend_par;
            clr_armed = 1'b1;
        end
        @(negedge CLK);
        cyc++;
        case (rmode)
            0:       TX_READY = 1'b1;
            1:       TX_READY = ((cyc % 2) == 0);
            default: TX_READY = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (prev_stall && (!TX_VALID || {TX_SOP, TX_EOP, TX_DATA} != prev_out)) stall_err++;
        prev_stall = TX_VALID && !TX_READY;
        prev_out   = {TX_SOP, TX_EOP, TX_DATA};
        if ((rd_total - data_acc) > 2) occ_err++;
        s_rd = RD_REQ;
        s_ms = MSG_START;
        if (RD_REQ) rd_total++;
        if (RD_REQ && MSG_START) both_err++;
        if (MSG_START) ms_log.push_back(cyc);
        if (TX_VALID) valid_cycles++;
        if (!BUSY) last_idle_cyc = cyc;
        if (TX_VALID && TX_READY) begin
            acc.push_back('{sop: TX_SOP, eop: TX_EOP, data: TX_DATA, cyc: cyc});
            if (!TX_SOP && !TX_EOP) data_acc++;
            if (TX_EOP) eop_count++;
        end
    endtask

    task automatic post_msg(input int len, input bit par, input logic [15:0] w [$]);
        foreach (w[i]) fifo.push_back(w[i]);
        pend_len = len;
        pend_par = par;
        GOT_FULL_MESSAGE = 1'b1;
    endtask

    // Reference frame: header, the message words in order, XOR of everything.
    task automatic build_expected(input int len, input bit par, input logic [15:0] w [$]);
        logic [15:0] hdr, x;
        exp_q.delete();
        hdr = {CHAN, 3'b000, par, 8'(len)};
        x   = hdr;
        exp_q.push_back({2'b10, hdr});
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({2'b00, w[i]});
            x = x ^ w[i];
        end
        exp_q.push_back({2'b01, x});
    endtask

    task automatic wait_frame(input string tag, input int budget);
        int start = eop_count;
        int n = 0;
        while (eop_count == start && n < budget) begin
            step();
            n++;
        end
        if (eop_count == start) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no trailer in %0d cycles, expected a trailer", tag, budget);
        end
    endtask

    task automatic compare_frame(input string tag, output logic [15:0] hdr, output logic [15:0] trl,
                                 output int sop_c, output int fd_c, output int eop_c);
        int e = -1;
        int cnt, n;
        hdr = 16'h0; trl = 16'h0; sop_c = 0; fd_c = 0; eop_c = 0;
        for (int i = 0; i < acc.size(); i++) if (acc[i].eop && e < 0) e = i;
        cnt = (e >= 0) ? e + 1 : acc.size();
        check({tag, "_beats"}, 32'(cnt), 32'(exp_q.size()));
        n = (cnt < exp_q.size()) ? cnt : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_beat%0d", tag, i), {14'b0, acc[i].sop, acc[i].eop, acc[i].data},
                  {14'b0, exp_q[i]});
        if (cnt > 0) begin
            hdr   = acc[0].data;
            sop_c = acc[0].cyc;
            trl   = acc[cnt-1].data;
            eop_c = acc[cnt-1].cyc;
        end
        if (cnt > 1) fd_c = acc[1].cyc;
        repeat (cnt) void'(acc.pop_front());
    endtask

    task automatic set_vec(input int idx, input int len, input bit par,
                           input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3,
                           input int rm, input logic [15:0] hdr, input logic [15:0] trl, input int rd);
        tbl[idx].len = len;   tbl[idx].par = par;
        tbl[idx].w[0] = w0;   tbl[idx].w[1] = w1;
        tbl[idx].w[2] = w2;   tbl[idx].w[3] = w3;
        tbl[idx].rmode = rm;  tbl[idx].exp_hdr = hdr;
        tbl[idx].exp_trl = trl; tbl[idx].exp_rd = rd;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] words [$];
        logic [15:0] hdr, trl;
        int sop_c, fd_c, eop_c, rd0, v0, ms0, min_d, eop1, base, n;

        set_vec(0, 3, 1'b1, 16'h1122, 16'h3344, 16'h5500, 16'h0000, 0, 16'h5103, 16'h2665, 3);
        set_vec(1, 4, 1'b0, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 0, 16'h5004, 16'h5000, 4);
        set_vec(2, 4, 1'b0, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 1, 16'h5004, 16'h5000, 4);
        set_vec(3, 2, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 2, 16'h5002, 16'hAFFD, 2);

        repeat (3) @(negedge CLK);
        #1;
        check("reset_outputs", {10'b0, RD_REQ, MSG_START, TX_VALID, TX_SOP, TX_EOP, BUSY, TX_DATA}, 32'h0);
        RST = 1'b1;
        repeat (2) step();

        // Directed table
        for (int v = 0; v < 4; v++) begin
            words.delete();
            for (int i = 0; i < tbl[v].len; i++) words.push_back(tbl[v].w[i]);
            rmode = tbl[v].rmode;
            rd0   = rd_total;
            post_msg(tbl[v].len, tbl[v].par, words);
            build_expected(tbl[v].len, tbl[v].par, words);
            wait_frame($sformatf("vec%0d", v), 200);
            compare_frame($sformatf("vec%0d", v), hdr, trl, sop_c, fd_c, eop_c);
            check($sformatf("vec%0d_hdr", v), 32'(hdr), 32'(tbl[v].exp_hdr));
            check($sformatf("vec%0d_trl", v), 32'(trl), 32'(tbl[v].exp_trl));
            check($sformatf("vec%0d_rd_count", v), 32'(rd_total - rd0), 32'(tbl[v].exp_rd));
            if (tbl[v].rmode == 0)
                check($sformatf("vec%0d_back_to_back", v), 32'(eop_c - fd_c), 32'(tbl[v].len));
            repeat (3) step();
        end

        // Randomised frames under random back-pressure
        rmode = 2;
        for (int f = 0; f < 6; f++) begin
            int len = $urandom_range(1, 12);
            bit par = 1'($urandom_range(0, 1));
            words.delete();
            for (int i = 0; i < len; i++) words.push_back(16'($urandom));
            rd0 = rd_total;
            post_msg(len, par, words);
            build_expected(len, par, words);
            wait_frame($sformatf("rnd%0d", f), 400);
            compare_frame($sformatf("rnd%0d", f), hdr, trl, sop_c, fd_c, eop_c);
            check($sformatf("rnd%0d_rd_count", f), 32'(rd_total - rd0), 32'(len));
            repeat ($urandom_range(1, 4)) step();
        end
        check("stall_stable", 32'(stall_err), 32'd0);
        check("occupancy_le_2", 32'(occ_err), 32'd0);
        check("rd_ms_overlap", 32'(both_err), 32'd0);

        // Saturated length with 300 words queued, then a 45-word message
        rmode = 0;
        words.delete();
        for (int i = 0; i < 300; i++) words.push_back(16'($urandom));
        foreach (words[i]) fifo.push_back(words[i]);
        pend_len = 255; pend_par = 1'b0; GOT_FULL_MESSAGE = 1'b1;
        exp_q.delete();
        begin
            logic [15:0] w255 [$];
            logic [15:0] w45 [$];
            for (int i = 0; i < 255; i++) w255.push_back(words[i]);
            for (int i = 255; i < 300; i++) w45.push_back(words[i]);
            build_expected(255, 1'b0, w255);
            base = data_acc;
            n = 0;
            while ((data_acc - base) < 100 && n < 1000) begin
                step();
                n++;
            end
            pend_len = 45; pend_par = 1'b1; GOT_FULL_MESSAGE = 1'b1;
            wait_frame("sat255", 1000);
            compare_frame("sat255", hdr, trl, sop_c, fd_c, eop_c);
            eop1 = eop_c;
            check("sat255_fifo_left", 32'(fifo.size()), 32'd45);
            build_expected(45, 1'b1, w45);
            wait_frame("len45", 300);
            compare_frame("len45", hdr, trl, sop_c, fd_c, eop_c);
            check("len45_idle_gap", 32'((last_idle_cyc > eop1) && (last_idle_cyc < sop_c)), 32'd1);
        end
        repeat (3) step();

        // Zero length with a stuck flag: no output, throttled restarts
        rd0 = rd_total; v0 = valid_cycles; ms0 = ms_log.size();
        pend_len = 0; pend_par = 1'b0; GOT_FULL_MESSAGE = 1'b1;
        repeat (80) step();
        check("drop_no_valid", 32'(valid_cycles - v0), 32'd0);
        check("drop_no_rd", 32'(rd_total - rd0), 32'd0);
        check("drop_ms_count_ge4", 32'((ms_log.size() - ms0) >= 4), 32'd1);
        min_d = 1000;
        for (int i = ms0 + 1; i < ms_log.size(); i++)
            if (ms_log[i] - ms_log[i-1] < min_d) min_d = ms_log[i] - ms_log[i-1];
        check("drop_ms_interval_ge19", 32'(min_d >= 19), 32'd1);
        GOT_FULL_MESSAGE = 1'b0;
        repeat (25) step();
        check("drop_back_idle", 32'(BUSY), 32'd0);

        // Reset in the middle of the data phase
        words.delete();
        for (int i = 0; i < 4; i++) words.push_back(16'h7000 + 16'(i));
        post_msg(4, 1'b0, words);
        base = data_acc;
        n = 0;
        while ((data_acc - base) < 2 && n < 100) begin
            step();
            n++;
        end
        check("rst_reached_data", 32'(data_acc - base), 32'd2);
        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("rst_async_outputs", {10'b0, RD_REQ, MSG_START, TX_VALID, TX_SOP, TX_EOP, BUSY, TX_DATA}, 32'h0);
        @(posedge CLK);
        #1;
        check("rst_next_cycle", {10'b0, RD_REQ, MSG_START, TX_VALID, TX_SOP, TX_EOP, BUSY, TX_DATA}, 32'h0);
        fifo.delete(); acc.delete();
        GOT_FULL_MESSAGE = 1'b0; FIFO_Q = 16'h0;
        s_rd = 0; s_ms = 0; clr_armed = 0; prev_stall = 0;
        rd_total = 0; data_acc = 0;
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) step();
        words.delete();
        words.push_back(16'hBEEF);
        words.push_back(16'h1234);
        post_msg(2, 1'b1, words);
        build_expected(2, 1'b1, words);
        wait_frame("post_rst", 200);
        compare_frame("post_rst", hdr, trl, sop_c, fd_c, eop_c);
        check("post_rst_hdr", 32'(hdr), 32'({CHAN, 3'b000, 1'b1, 8'd2}));
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_msg_framer.md
Name: uart_msg_framer

Overview:
- Downstream stage of the UART input processor: consumes its 16-bit word FIFO and its message-ready flags.
- Frames each buffered UART message as header, data words and checksum trailer on a 16-bit valid/ready stream to the board's output mux.
- Owns the MSG_START / RD_REQ side of the upstream handshake.

Parameters:
- CHAN_ID, 4'd0, channel number placed in header bits [15:12].
- SETTLE, 3, idle cycles after the length is latched and before the first RD_REQ; covers FIFO used-word synchronisation after the stuffing write.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-low reset.
- GOT_FULL_MESSAGE  in  1  upstream message-ready flag; cleared upstream by RD_REQ.
- MSG_LEN  in  8  word count, registered upstream on MSG_START; 255 means saturated.
- PARITY_IN  in  1  last word carries a stuffed byte; registered upstream on MSG_START.
- FIFO_Q  in  16  FIFO read data, valid the cycle after RD_REQ.
- RD_REQ  out  1  FIFO read strobe, one word per cycle.
- MSG_START  out  1  one-cycle pulse that freezes length and parity upstream.
- TX_DATA  out  16  output word.
- TX_VALID  out  1  TX_DATA valid.
- TX_READY  in  1  downstream accepts when TX_VALID&TX_READY.
- TX_SOP  out  1  marks the header word.
- TX_EOP  out  1  marks the trailer word.
- BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - All outputs 0; FSM goes to IDLE.
  - Skid buffer emptied; checksum and counters cleared.
  - Reset mid-message abandons the frame with no trailer; FIFO contents are not flushed.
- FSM: IDLE -> START -> LATCH -> SETTLE -> HDR -> DATA -> TRL -> IDLE; DROP is an alternate exit from LATCH.
- IDLE: when GOT_FULL_MESSAGE=1, go to START.
- START: MSG_START=1 for exactly one cycle; go to LATCH.
- LATCH:
  - Register MSG_LEN into len_r and PARITY_IN into par_r.
  - If len_r==0, go to DROP; otherwise go to SETTLE.
- SETTLE: wait SETTLE cycles, then go to HDR.
- HDR:
  - Present header {CHAN_ID, 3'b000, par_r, len_r} with TX_VALID=1 and TX_SOP=1.
  - Checksum is initialised to the header word.
  - On handshake, go to DATA.
- DATA, reads:
  - RD_REQ is asserted only while words_req < len_r and (buffered + in_flight) < 2.
  - The skid buffer is 2 entries. FIFO_Q is captured the cycle after RD_REQ.
- DATA, output:
  - TX_DATA is the skid head. Each accepted word is XORed into the checksum and increments words_sent.
  - When words_sent reaches len_r, go to TRL.
  - Full throughput: back-to-back words with TX_READY held high, one word per cycle after the initial 1-cycle read latency.
- TRL:
  - TX_DATA = checksum, TX_VALID=1, TX_EOP=1.
  - On handshake, go to IDLE.
  - GOT_FULL_MESSAGE is re-evaluated in IDLE the next cycle; at least 1 idle cycle between frames.
- DROP:
  - No output, no RD_REQ. Wait 16 cycles, then go to IDLE.
  - Prevents a spin on a stale flag.
- Stream rule: TX_DATA, TX_SOP and TX_EOP are stable while TX_VALID=1 and TX_READY=0; TX_VALID never drops without a handshake.
- Saturated length: len_r=255 sends exactly 255 words. Remaining FIFO words stay for the next message.
- Widths: words_req and words_sent are 8-bit and never wrap, since the bound is ≤255.
- Upstream flag changes: GOT_FULL_MESSAGE deasserting mid-frame is ignored; the frame completes.
- RD_REQ and MSG_START are never asserted in the same cycle.

Test Plan:
- 5 bytes 11..55 written upstream, timeout fires -> MSG_START pulse, len_r=3, par_r=1; header 0x0103; data 0x1122, 0x3344, 0x5500; trailer = XOR of all four words; TX_SOP only on the header, TX_EOP only on the trailer.
- CHAN_ID=5, 4 words with TX_READY=1 -> 6 consecutive output words; RD_REQ count exactly 4; never more than 2 words buffered or in flight.
- Same 4-word message with TX_READY toggling 1/0 each cycle -> data order preserved, outputs held stable on stall, no lost or duplicated words, RD_REQ count still 4.
- MSG_LEN=255 with 300 words queued -> exactly 255 data words framed; second frame starts ≥1 idle cycle later with len 45.
- MSG_LEN forced to 0 with GOT_FULL_MESSAGE stuck at 1 -> no TX_VALID and no RD_REQ; MSG_START repeats no more often than once per 19 cycles.
- RST low during DATA after 2 of 4 words -> all outputs 0 next cycle, BUSY=0; after release a new GOT_FULL_MESSAGE produces a clean header.
